// File: rtl/reg_file_wb_if.sv
// Bus between write_back/decode and the register file: the retire-side commit
// inputs, the two decode read ports, and the processor status outputs.
interface reg_file_wb_if #(
   parameter int CNT_W = 32
);
   logic             wb_valid_i;
   logic [3:0]       icode_i;
   logic [3:0]       dstE_i;
   logic [3:0]       dstM_i;
   logic [63:0]      valE_i;
   logic [63:0]      valM_i;
   logic             instr_valid_i;
   logic             imem_error_i;
   logic             dmem_error_i;
   logic [3:0]       srcA_i;
   logic [3:0]       srcB_i;
   logic [63:0]      valA_o;
   logic [63:0]      valB_o;
   logic [2:0]       stat_o;
   logic             halted_o;
   logic [CNT_W-1:0] retired_cnt_o;

   modport master (
      output wb_valid_i, icode_i, dstE_i, dstM_i, valE_i, valM_i,
             instr_valid_i, imem_error_i, dmem_error_i, srcA_i, srcB_i,
      input  valA_o, valB_o, stat_o, halted_o, retired_cnt_o
   );

   modport slave (
      input  wb_valid_i, icode_i, dstE_i, dstM_i, valE_i, valM_i,
             instr_valid_i, imem_error_i, dmem_error_i, srcA_i, srcB_i,
      output valA_o, valB_o, stat_o, halted_o, retired_cnt_o
   );
endinterface

// File: rtl/reg_file_wb.sv
// Y86-64 architectural register file with sticky processor status and a
// retired-instruction counter. Commits up to two writes per retiring
// instruction; serves two combinational reads with no write bypass.
//
//   stat | meaning
//   -----+----------------------------------------------
//   AOK  | running normally, retires are committed
//   HLT  | halt retired; all further retires ignored
//   ADR  | instruction or data address fault; frozen
//   INS  | illegal instruction retired; frozen
module reg_file_wb #(
   parameter int          NUM_REGS = 15,
   parameter int          CNT_W    = 32,
   parameter logic [63:0] SP_INIT  = 64'h0
) (
   input logic           clk_i,
   input logic           rst_i,
   reg_file_wb_if.slave  bus
);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [4:0] NREGS = NUM_REGS[4:0];
   localparam int         SP_ID = 4;

   logic [63:0]      regs_q [NUM_REGS];
   logic [2:0]       stat_q;
   logic [CNT_W-1:0] cnt_q;

   logic [2:0] inst_stat;
   logic       halted;
   logic       upd;
   logic       commit;
   logic       wr_e;
   logic       wr_m;
   logic       src_a_ok;
   logic       src_b_ok;

   // Status of the retiring instruction; earlier faults mask later ones.
   always_comb begin
      inst_stat = STAT_AOK;
      if (bus.imem_error_i)        inst_stat = STAT_ADR;
      else if (!bus.instr_valid_i) inst_stat = STAT_INS;
      else if (bus.dmem_error_i)   inst_stat = STAT_ADR;
      else if (bus.icode_i == 4'h0) inst_stat = STAT_HLT;
   end

   assign halted = (stat_q != STAT_AOK);
   assign upd    = bus.wb_valid_i && !halted;
   assign commit = upd && (inst_stat == STAT_AOK);

   // IDs at or above NUM_REGS (including RNONE) never address the array.
   assign wr_e     = ({1'b0, bus.dstE_i} < NREGS);
   assign wr_m     = ({1'b0, bus.dstM_i} < NREGS);
   assign src_a_ok = ({1'b0, bus.srcA_i} < NREGS);
   assign src_b_ok = ({1'b0, bus.srcB_i} < NREGS);

   // Register array: reset image, then commit writes with valM taking a shared destination.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= (i == SP_ID) ? SP_INIT : 64'h0;
         end
      end else if (commit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_m && (bus.dstM_i == 4'(i))) begin
               regs_q[i] <= bus.valM_i;
            end else if (wr_e && (bus.dstE_i == 4'(i))) begin
               regs_q[i] <= bus.valE_i;
            end
         end
      end
   end

   // Sticky status: latches the first non-AOK instruction status until reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_q <= STAT_AOK;
      end else if (upd) begin
         stat_q <= inst_stat;
      end
   end

   // Retired count includes the halt instruction but not faulting ones.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (upd && ((inst_stat == STAT_AOK) || (inst_stat == STAT_HLT))) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.valA_o        = src_a_ok ? regs_q[bus.srcA_i] : 64'h0;
   assign bus.valB_o        = src_b_ok ? regs_q[bus.srcB_i] : 64'h0;
   assign bus.stat_o        = stat_q;
   assign bus.halted_o      = halted;
   assign bus.retired_cnt_o = cnt_q;

endmodule
